tea32_cipher: RTL and testbench



---
 rtl/tea32_cipher.sv | 160 ++++++++++++++++
 tb/tb_tea32_cipher.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tea32_cipher.sv
// rtl/tea32_cipher.sv - 32-bit-block TEA engine, req/ack handshake in pclk, rounds in clk
module tea32_cipher #(
    parameter bit          MODE     = 1'b0,
    parameter int          ROUNDS   = 32,
    parameter logic [15:0] DELTA    = 16'h9E37,
    parameter logic [63:0] KEY_INIT = 64'h0123_4567_89AB_CDEF
) (
    input  logic        prstb,
    input  logic        pclk,
    input  logic        clk,
    input  logic        req,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata
);

    localparam int          CW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST   = CW'(ROUNDS - 1);
    localparam logic [31:0] SUM_FULL = 32'(DELTA) * 32'(ROUNDS);
    localparam logic [15:0] SUM_INIT = MODE ? SUM_FULL[15:0] : 16'h0000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_SIG} state_t;

    // pclk domain
    logic [63:0] key;
    logic [63:0] key_snap;
    logic [31:0] blk_q;
    logic        start_tgl;
    logic [1:0]  done_sync;
    logic        done_seen;
    logic        apb_wr;
    logic        done_edge;

    // clk domain
    state_t      state;
    logic [1:0]  start_sync;
    logic        start_seen;
    logic        start_edge;
    logic [CW-1:0] cnt;
    logic [15:0] v0, v1, sum;
    logic [15:0] v0_nx, v1_nx, sum_nx;
    logic [31:0] result;
    logic        done_tgl;

    // Only paddr[3:2] selects a key word; the remaining bits are don't-care.
    logic unused_paddr;
    assign unused_paddr = ^{paddr[31:4], paddr[1:0]};

    assign apb_wr     = psel & penable & pwrite;
    assign done_edge  = done_sync[1] ^ done_seen;
    assign start_edge = start_sync[1] ^ start_seen;

    function automatic logic [15:0] tea_f(input logic [15:0] x, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] s);
        return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
    endfunction

    // Key register, start capture and completion hand-back in the pclk domain.
    // key_snap and blk_q only change while the core is idle, so the core may
    // read them directly across the clock boundary.
    always_ff @(posedge pclk or negedge prstb) begin
        if (!prstb) begin
            key       <= KEY_INIT;
            key_snap  <= KEY_INIT;
            blk_q     <= 32'h0;
            ack       <= 1'b1;
            rdata     <= 32'h0;
            start_tgl <= 1'b0;
            done_sync <= 2'b00;
            done_seen <= 1'b0;
        end else begin
            if (apb_wr && paddr[3:2] == 2'd0) begin
                key[31:0] <= pwdata;
            end else if (apb_wr && paddr[3:2] == 2'd1) begin
                key[63:32] <= pwdata;
            end
            done_sync <= {done_sync[0], done_tgl};
            done_seen <= done_sync[1];
            if (ack && req) begin
                blk_q     <= wdata;
                key_snap  <= key;
                ack       <= 1'b0;
                start_tgl <= ~start_tgl;
            end else if (!ack && done_edge) begin
                rdata <= result;
                ack   <= 1'b1;
            end
        end
    end

    // One full TEA cycle (both half-rounds) of combinational datapath.
    always_comb begin
        v0_nx  = v0;
        v1_nx  = v1;
        sum_nx = sum;
        if (MODE) begin
            v1_nx  = v1 - tea_f(v0, key_snap[47:32], key_snap[63:48], sum);
            v0_nx  = v0 - tea_f(v1_nx, key_snap[15:0], key_snap[31:16], sum);
            sum_nx = sum - DELTA;
        end else begin
            sum_nx = sum + DELTA;
            v0_nx  = v0 + tea_f(v1, key_snap[15:0], key_snap[31:16], sum_nx);
            v1_nx  = v1 + tea_f(v0_nx, key_snap[47:32], key_snap[63:48], sum_nx);
        end
    end

    // Round sequencer: sync start, run ROUNDS cycles, publish result, then flip done.
    // The result settles one clk before the done toggle so it is stable when sampled.
    always_ff @(posedge clk or negedge prstb) begin
        if (!prstb) begin
            state      <= S_IDLE;
            start_sync <= 2'b00;
            start_seen <= 1'b0;
            cnt        <= '0;
            v0         <= 16'h0;
            v1         <= 16'h0;
            sum        <= 16'h0;
            result     <= 32'h0;
            done_tgl   <= 1'b0;
        end else begin
            start_sync <= {start_sync[0], start_tgl};
            start_seen <= start_sync[1];
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        v0    <= blk_q[15:0];
                        v1    <= blk_q[31:16];
                        sum   <= SUM_INIT;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    v0  <= v0_nx;
                    v1  <= v1_nx;
                    sum <= sum_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    result <= {v1, v0};
                    state  <= S_SIG;
                end
                S_SIG: begin
                    done_tgl <= ~done_tgl;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea32_cipher.sv
// tb/tb_tea32_cipher.sv - scoreboard bench for tea32_cipher encrypt/decrypt pair
module tb_tea32_cipher;

    localparam int          PCLK_P   = 10;
    localparam int          CLK_P    = 4;
    localparam logic [63:0] KEY_INIT = 64'h0123_4567_89AB_CDEF;
    localparam int          LIM      = ((32 + 8) * CLK_P + 4 * PCLK_P) / PCLK_P + 1;

    logic        pclk, clk, prstb;
    logic        e_req, d_req, e_ack, d_ack;
    logic [31:0] e_wdata, d_wdata, e_rdata, d_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;

    logic [63:0] cur_key;
    logic [31:0] enc_q[$];
    logic [31:0] dec_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] blk, r, r2, r_enc, r_dec, prev_r, prev_blk;

    tea32_cipher #(.MODE(1'b0)) u_enc (
        .prstb(prstb), .pclk(pclk), .clk(clk), .req(e_req), .wdata(e_wdata),
        .ack(e_ack), .rdata(e_rdata), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata)
    );

    tea32_cipher #(.MODE(1'b1)) u_dec (
        .prstb(prstb), .pclk(pclk), .clk(clk), .req(d_req), .wdata(d_wdata),
        .ack(d_ack), .rdata(d_rdata), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata)
    );

    initial pclk = 1'b0;
    always #(PCLK_P / 2) pclk = ~pclk;
    initial begin
        clk = 1'b0;
        #1;
        forever #(CLK_P / 2) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tea_model(input logic [31:0] b, input logic [63:0] k);
        logic [15:0] y, z, s;
        y = b[15:0];
        z = b[31:16];
        s = 16'h0;
        for (int i = 0; i < 32; i++) begin
            s = s + 16'h9E37;
            y = y + (((z << 4) + k[15:0]) ^ (z + s) ^ ((z >> 5) + k[31:16]));
            z = z + (((y << 4) + k[47:32]) ^ (y + s) ^ ((y >> 5) + k[63:48]));
        end
        return {z, y};
    endfunction

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (a[3:2] == 2'd0) cur_key[31:0] = d;
        else if (a[3:2] == 2'd1) cur_key[63:32] = d;
    endtask

    task automatic run_block(input bit dec, input logic [31:0] b, input logic [31:0] expv,
                             input string tag, output logic [31:0] res);
        int          n;
        bit          stable;
        logic [31:0] old, e;
        @(negedge pclk);
        if (dec) begin
            d_wdata = b; d_req = 1'b1; dec_q.push_back(expv); old = d_rdata;
        end else begin
            e_wdata = b; e_req = 1'b1; enc_q.push_back(expv); old = e_rdata;
        end
        @(negedge pclk);
        if (dec) d_req = 1'b0; else e_req = 1'b0;
        chk({tag, "_busy"}, dec ? d_ack : e_ack, 0);
        n = 0;
        stable = 1'b1;
        while (!(dec ? d_ack : e_ack) && n < LIM) begin
            if ((dec ? d_rdata : e_rdata) !== old) stable = 1'b0;
            @(negedge pclk);
            n++;
        end
        chk({tag, "_hold"}, stable, 1);
        chk({tag, "_lat"}, n < LIM, 1);
        res = dec ? d_rdata : e_rdata;
        e = dec ? dec_q.pop_front() : enc_q.pop_front();
        chk(tag, res, e);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prstb = 1'b0;
        e_req = 1'b0; d_req = 1'b0; e_wdata = '0; d_wdata = '0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        cur_key = KEY_INIT;
        repeat (3) @(negedge pclk);
        chk("rst_ack", e_ack, 1);
        chk("rst_rdata", e_rdata, 0);
        chk("rst_dec_ack", d_ack, 1);
        prstb = 1'b1;
        repeat (20) @(negedge pclk);
        chk("idle_ack", e_ack, 1);
        chk("idle_rdata", e_rdata, 0);

        run_block(1'b0, 32'h0, tea_model(32'h0, cur_key), "enc0", r);
        chk("enc0_nz", r != 32'h0, 1);

        for (int i = 0; i <= 1000; i++) begin
            blk = $urandom;
            fork
                begin
                    if (i < 1000) run_block(1'b0, blk, tea_model(blk, cur_key), "rt_enc", r_enc);
                end
                begin
                    if (i > 0) run_block(1'b1, prev_r, prev_blk, "rt_dec", r_dec);
                end
            join
            prev_r   = r_enc;
            prev_blk = blk;
        end

        apb_write(32'h0, 32'hDEAD_BEEF);
        apb_write(32'h4, 32'h0BAD_F00D);
        run_block(1'b0, 32'h1234_5678, tea_model(32'h1234_5678, cur_key), "key_enc", r);
        chk("key_diff", r != tea_model(32'h1234_5678, KEY_INIT), 1);
        run_block(1'b1, r, 32'h1234_5678, "key_dec", r2);
        apb_write(32'h8, 32'hFFFF_FFFF);
        run_block(1'b0, 32'h1234_5678, tea_model(32'h1234_5678, cur_key), "key_addr8", r);

        fork
            run_block(1'b0, 32'hA5A5_5A5A, tea_model(32'hA5A5_5A5A, cur_key), "busy_key", r);
            begin
                repeat (4) @(negedge pclk);
                apb_write(32'h0, 32'hCAFE_1234);
            end
        join
        run_block(1'b0, 32'hA5A5_5A5A, tea_model(32'hA5A5_5A5A, cur_key), "new_key", r);

        @(negedge pclk);
        e_wdata = 32'h7777_0001; e_req = 1'b1;
        @(negedge pclk);
        e_req = 1'b0;
        repeat (5) @(negedge pclk);
        chk("mid_busy", e_ack, 0);
        prstb = 1'b0;
        #1;
        chk("mid_ack", e_ack, 1);
        chk("mid_rdata", e_rdata, 0);
        cur_key = KEY_INIT;
        repeat (3) @(negedge pclk);
        prstb = 1'b1;
        repeat (2) @(negedge pclk);
        run_block(1'b0, 32'h7777_0001, tea_model(32'h7777_0001, cur_key), "post_rst", r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
